// File: rtl/rgb2ac1c2_stream_ctrl.sv
// rgb2ac1c2_stream_ctrl: frame-sequenced RGB -> A/C1/C2 colour transform.
// A 3x3 Q3.13 coefficient matrix is applied to each accepted pixel through a
// two-stage pipeline (products, then sums). Each output is formatted as
// {4'b0, sum[24:0], 3'b0}. Flags mark the start of frame, end of line and
// end of frame.
// Optional feature: define AC1C2_CLAMP_NEG_EN to replace negative sums with 0.
module rgb2ac1c2_stream_ctrl #(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_coef_we,
    input  logic [3:0]  i_coef_addr,
    input  logic [15:0] i_coef_data,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [7:0]  i_R,
    input  logic [7:0]  i_G,
    input  logic [7:0]  i_B,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_A,
    output logic [31:0] o_C1,
    output logic [31:0] o_C2,
    output logic        o_sof,
    output logic        o_eol,
    output logic        o_eof,
    output logic        o_busy,
    output logic        o_done
);

    localparam int unsigned COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int unsigned ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t              state;
    logic [COL_W-1:0]    col;
    logic [ROW_W-1:0]    row;
    logic signed [15:0]  coef [9];

    logic                s1_valid;
    logic                s1_sof;
    logic                s1_eol;
    logic                s1_eof;
    logic signed [24:0]  s1_p [9];

    logic                advance;
    logic                accept;
    logic                last_px;
    logic                drained;
    logic signed [8:0]   px [3];

    // Pixels are unsigned 8-bit, widened to 9-bit signed for the multiply.
    assign px[0] = $signed({1'b0, i_R});
    assign px[1] = $signed({1'b0, i_G});
    assign px[2] = $signed({1'b0, i_B});

    // Pipeline moves whenever the output register is free or being consumed.
    assign advance = !o_valid || i_ready;
    assign o_ready = (state == RUN) && advance;
    assign accept  = i_valid && o_ready;
    assign last_px = (col == COL_LAST) && (row == ROW_LAST);
    // True when both stages will be empty after this edge.
    assign drained = !s1_valid && (!o_valid || i_ready);

    function automatic logic signed [24:0] sum3(
        input logic signed [24:0] a,
        input logic signed [24:0] b,
        input logic signed [24:0] c
    );
        return a + b + c;
    endfunction

    function automatic logic [31:0] fmt(input logic signed [24:0] s);
        logic [24:0] v;
`ifdef AC1C2_CLAMP_NEG_EN
        v = s[24] ? 25'd0 : s;
`else
        v = s;
`endif
        return {4'b0, v, 3'b0};
    endfunction

    // Frame sequencer: state, pixel position counters, busy and done.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= IDLE;
            col    <= '0;
            row    <= '0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state  <= RUN;
                        o_busy <= 1'b1;
                        col    <= '0;
                        row    <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (col == COL_LAST) begin
                            col <= '0;
                            row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                        if (last_px) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (drained) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

    // Coefficient bank: reset defaults, writable only while idle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            coef[0] <= 16'sd7865;
            coef[1] <= 16'sd15462;
            coef[2] <= 16'sd1638;
            coef[3] <= 16'sd1383;
            coef[4] <= -16'sd1636;
            coef[5] <= 16'sd254;
            coef[6] <= 16'sd477;
            coef[7] <= 16'sd942;
            coef[8] <= -16'sd1415;
        end else if ((state == IDLE) && i_coef_we) begin
            for (int k = 0; k < 9; k++) begin
                if (i_coef_addr == 4'(k)) begin
                    coef[k] <= $signed(i_coef_data);
                end
            end
        end
    end

    // Two-stage datapath: stage 1 products, stage 2 sums into output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_sof   <= 1'b0;
            s1_eol   <= 1'b0;
            s1_eof   <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                s1_p[k] <= '0;
            end
            o_valid  <= 1'b0;
            o_A      <= '0;
            o_C1     <= '0;
            o_C2     <= '0;
            o_sof    <= 1'b0;
            o_eol    <= 1'b0;
            o_eof    <= 1'b0;
        end else if (advance) begin
            s1_valid <= accept;
            s1_sof   <= (col == '0) && (row == '0);
            s1_eol   <= (col == COL_LAST);
            s1_eof   <= last_px;
            for (int k = 0; k < 9; k++) begin
                s1_p[k] <= 25'(coef[k]) * 25'(px[k % 3]);
            end
            o_valid  <= s1_valid;
            o_A      <= fmt(sum3(s1_p[0], s1_p[1], s1_p[2]));
            o_C1     <= fmt(sum3(s1_p[3], s1_p[4], s1_p[5]));
            o_C2     <= fmt(sum3(s1_p[6], s1_p[7], s1_p[8]));
            o_sof    <= s1_sof;
            o_eol    <= s1_eol;
            o_eof    <= s1_eof;
        end
    end

endmodule

// File: tb/tb_rgb2ac1c2_stream_ctrl.sv
// Directed bench for rgb2ac1c2_stream_ctrl: a 1x1 instance for single-pixel
// arithmetic and coefficient handling, a 4x2 instance for framing, stalls
// and mid-frame reset. Honours AC1C2_CLAMP_NEG_EN for expected values.
module tb_rgb2ac1c2_stream_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance a: WIDTH=1, HEIGHT=1
    logic        a_start = 0, a_we = 0, a_valid = 0, a_iready = 1;
    logic [3:0]  a_addr = 0;
    logic [15:0] a_data = 0;
    logic [7:0]  a_R = 0, a_G = 0, a_B = 0;
    logic        a_ready, a_ovalid, a_sof, a_eol, a_eof, a_busy, a_done;
    logic [31:0] a_A, a_C1, a_C2;

    // Instance b: WIDTH=4, HEIGHT=2
    logic        b_start = 0, b_we = 0, b_valid = 0, b_iready = 1;
    logic [3:0]  b_addr = 0;
    logic [15:0] b_data = 0;
    logic [7:0]  b_R = 0, b_G = 0, b_B = 0;
    logic        b_ready, b_ovalid, b_sof, b_eol, b_eof, b_busy, b_done;
    logic [31:0] b_A, b_C1, b_C2;

    rgb2ac1c2_stream_ctrl #(.WIDTH(1), .HEIGHT(1)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(a_start),
        .i_coef_we(a_we), .i_coef_addr(a_addr), .i_coef_data(a_data),
        .i_valid(a_valid), .o_ready(a_ready), .i_R(a_R), .i_G(a_G), .i_B(a_B),
        .o_valid(a_ovalid), .i_ready(a_iready), .o_A(a_A), .o_C1(a_C1), .o_C2(a_C2),
        .o_sof(a_sof), .o_eol(a_eol), .o_eof(a_eof), .o_busy(a_busy), .o_done(a_done)
    );

    rgb2ac1c2_stream_ctrl #(.WIDTH(4), .HEIGHT(2)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(b_start),
        .i_coef_we(b_we), .i_coef_addr(b_addr), .i_coef_data(b_data),
        .i_valid(b_valid), .o_ready(b_ready), .i_R(b_R), .i_G(b_G), .i_B(b_B),
        .o_valid(b_ovalid), .i_ready(b_iready), .o_A(b_A), .o_C1(b_C1), .o_C2(b_C2),
        .o_sof(b_sof), .o_eol(b_eol), .o_eof(b_eof), .o_busy(b_busy), .o_done(b_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

`ifdef AC1C2_CLAMP_NEG_EN
    localparam logic [31:0] EXP_C1_G255 = 32'd0;
`else
    localparam logic [31:0] EXP_C1_G255 = 32'd265098016;
`endif

    // Output monitor for instance b: records transfers and checks stall behaviour.
    logic [31:0] q_a [$];
    logic [2:0]  q_f [$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_a = '0;

    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold_valid", 32'(b_ovalid), 32'd1);
                chk("stall_hold_A", b_A, prev_a);
            end
            if (b_ovalid && !b_iready) chk("stall_ready_low", 32'(b_ready), 32'd0);
            if (b_ovalid && b_iready) begin
                q_a.push_back(b_A);
                q_f.push_back({b_sof, b_eol, b_eof});
            end
            prev_stall = b_ovalid && !b_iready;
            prev_a     = b_A;
        end
    end

    task automatic a_wr(input logic [3:0] addr, input logic [15:0] data);
        @(negedge clk);
        a_we = 1; a_addr = addr; a_data = data;
        @(negedge clk);
        a_we = 0;
    endtask

    // One single-pixel frame on instance a, optionally writing m11 with start or in RUN.
    task automatic a_run(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input bit wr_start, input bit wr_run, input logic [15:0] wd,
                         output logic [31:0] oa, output logic [31:0] oc1, output logic [31:0] oc2);
        int n;
        @(negedge clk);
        a_start = 1;
        if (wr_start) begin a_we = 1; a_addr = 4'd0; a_data = wd; end
        @(negedge clk);
        a_start = 0; a_we = 0;
        if (wr_run) begin
            a_we = 1; a_addr = 4'd0; a_data = wd;
            @(negedge clk);
            a_we = 0;
        end
        a_valid = 1; a_R = r; a_G = g; a_B = b;
        @(negedge clk);
        a_valid = 0;
        n = 0;
        while (!a_ovalid && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("a_latency", 32'(n), 32'd1);
        oa = a_A; oc1 = a_C1; oc2 = a_C2;
        n = 0;
        while (a_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("a_back_idle", 32'(a_busy), 32'd0);
    endtask

    // Frame on instance b: pixel k carries R=k+1; i_ready low for 5 cycles from stall_at.
    task automatic b_frame(input int stall_at, input int n_px, input bit wait_done);
        int idx, cyc, n;
        q_a.delete();
        q_f.delete();
        @(negedge clk);
        b_start = 1;
        @(negedge clk);
        b_start = 0;
        idx = 0; cyc = 0;
        while (idx < n_px && cyc < 100) begin
            b_iready = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 5);
            b_valid  = 1;
            b_R      = 8'(idx + 1);
            #1;
            if (b_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        b_valid = 0; b_iready = 1;
        chk("b_accepted", 32'(idx), 32'(n_px));
        if (wait_done) begin
            #1;
            chk("b_ready_after_last", 32'(b_ready), 32'd0);
            n = 0;
            while (b_busy && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("b_drained", 32'(b_busy), 32'd0);
            @(negedge clk);
        end
    endtask

    task automatic b_check_frame();
        chk("b_out_count", 32'(q_a.size()), 32'd8);
        for (int i = 0; i < 8 && i < q_a.size(); i++) begin
            chk("b_out_A", q_a[i], 32'(62920 * (i + 1)));
            chk("b_out_flags", 32'(q_f[i]), 32'({i == 0, (i % 4) == 3, i == 7}));
        end
    endtask

    initial begin
        logic [31:0] ra, rc1, rc2;
        repeat (3) @(negedge clk);
        rst = 0;

        // Reset state
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_ready", 32'(a_ready), 32'd0);
        chk("rst_valid", 32'(a_ovalid), 32'd0);
        chk("rst_A", a_A, 32'd0);
        chk("rst_done", 32'(a_done), 32'd0);

        // Single pixel R=1 with default coefficients, checked cycle by cycle
        @(negedge clk);
        a_start = 1;
        @(negedge clk);
        a_start = 0;
        chk("a1_busy", 32'(a_busy), 32'd1);
        #1;
        chk("a1_ready_run", 32'(a_ready), 32'd1);
        a_valid = 1; a_R = 8'd1; a_G = 8'd0; a_B = 8'd0;
        @(negedge clk);
        a_valid = 0;
        chk("a1_valid_early", 32'(a_ovalid), 32'd0);
        chk("a1_ready_flush", 32'(a_ready), 32'd0);
        @(negedge clk);
        chk("a1_valid", 32'(a_ovalid), 32'd1);
        chk("a1_A", a_A, 32'd62920);
        chk("a1_C1", a_C1, 32'd11064);
        chk("a1_C2", a_C2, 32'd3816);
        chk("a1_flags", 32'({a_sof, a_eol, a_eof}), 32'd7);
        chk("a1_done_early", 32'(a_done), 32'd0);
        @(negedge clk);
        chk("a1_done", 32'(a_done), 32'd1);
        chk("a1_valid_gone", 32'(a_ovalid), 32'd0);
        chk("a1_idle", 32'(a_busy), 32'd0);
        @(negedge clk);
        chk("a1_done_pulse", 32'(a_done), 32'd0);

        // Negative C1 sum
        a_run(8'd0, 8'd255, 8'd0, 1'b0, 1'b0, 16'd0, ra, rc1, rc2);
        chk("a2_A", ra, 32'd31542480);
        chk("a2_C1", rc1, EXP_C1_G255);
        chk("a2_C2", rc2, 32'd1921680);

        // m11 write in IDLE takes effect; the same style of write during RUN is ignored
        a_wr(4'd0, 16'd8192);
        a_run(8'd1, 8'd0, 8'd0, 1'b0, 1'b1, 16'd100, ra, rc1, rc2);
        chk("a3_A_m11", ra, 32'd65536);
        chk("a3_C1", rc1, 32'd11064);

        // Write coinciding with start is performed
        a_run(8'd1, 8'd0, 8'd0, 1'b1, 1'b0, 16'd4096, ra, rc1, rc2);
        chk("a4_A_start_wr", ra, 32'd32768);

        // Address 9 is ignored (must not alias m12)
        a_wr(4'd9, 16'd0);
        a_run(8'd0, 8'd1, 8'd0, 1'b0, 1'b0, 16'd0, ra, rc1, rc2);
        chk("a5_A_addr9", ra, 32'd123696);

        // 4x2 frame, continuous
        b_frame(-1, 8, 1'b1);
        b_check_frame();

        // 4x2 frame with a 5-cycle output stall
        b_frame(3, 8, 1'b1);
        b_check_frame();

        // Reset after 3 of 8 pixels
        b_frame(-1, 3, 1'b0);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("brst_valid", 32'(b_ovalid), 32'd0);
        chk("brst_A", b_A, 32'd0);
        chk("brst_C1", b_C1, 32'd0);
        chk("brst_C2", b_C2, 32'd0);
        chk("brst_flags", 32'({b_sof, b_eol, b_eof}), 32'd0);
        chk("brst_busy", 32'(b_busy), 32'd0);
        chk("brst_ready", 32'(b_ready), 32'd0);
        chk("brst_done", 32'(b_done), 32'd0);
        b_frame(-1, 8, 1'b1);
        b_check_frame();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
